// File: rtl/shared_mem_arbiter_pkg.sv
// Shared definitions for the I/D shared-memory arbiter: owner encoding,
// memory latency bounds and byte-enable width helper.
package shared_mem_arbiter_pkg;

    // Owner of a request / in-flight read. The encoding is also the value
    // stored in the response tag delay line.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Supported range for the memory read latency in cycles.
    localparam int MEM_LATENCY_MIN = 1;
    localparam int MEM_LATENCY_MAX = 4;

    // True when a latency value can be handled by the tag delay line.
    function automatic bit latency_ok(input int latency);
        return (latency >= MEM_LATENCY_MIN) && (latency <= MEM_LATENCY_MAX);
    endfunction

    // One write-enable bit per data byte.
    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/shared_mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the memory macro port
// seen by the shared memory arbiter.
interface shared_mem_arbiter_if
    import shared_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);

    localparam int BE_WIDTH = be_width(DATA_WIDTH);

    // Instruction fetch requester
    logic                  i_req_valid;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic                  i_req_ready;
    logic                  i_resp_valid;
    logic [DATA_WIDTH-1:0] i_resp_data;

    // Data load/store requester
    logic                  d_req_valid;
    logic [ADDR_WIDTH-1:0] d_req_addr;
    logic [BE_WIDTH-1:0]   d_req_be;
    logic [DATA_WIDTH-1:0] d_req_wdata;
    logic                  d_req_ready;
    logic                  d_resp_valid;
    logic [DATA_WIDTH-1:0] d_resp_data;

    // Single-port synchronous memory
    logic                  mem_en;
    logic [BE_WIDTH-1:0]   mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    // Arbiter side: takes requests and memory read data, drives everything else.
    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_resp_valid, i_resp_data,
        input  d_req_valid, d_req_addr, d_req_be, d_req_wdata,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    // Environment side: requesters plus the memory macro.
    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_resp_valid, i_resp_data,
        output d_req_valid, d_req_addr, d_req_be, d_req_wdata,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );

endinterface

// File: rtl/shared_mem_arbiter_resp_tag_pipe.sv
// Response tag delay line: carries {valid, owner} of each issued read for
// DEPTH cycles so the tail lines up with the memory read data.
module shared_mem_arbiter_resp_tag_pipe
    import shared_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    input  owner_e in_owner,
    output logic   out_valid,
    output owner_e out_owner
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] owner_q;

    // Shift tags toward the tail; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            owner_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            owner_q[0] <= in_owner;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                owner_q[i] <= owner_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_owner = owner_e'(owner_q[DEPTH-1]);

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// the instruction fetch (I) and data load/store (D) requesters. One request
// is issued per cycle; reads are tagged with their owner and the memory data
// is steered back to that owner MEM_LATENCY cycles later.
module shared_mem_arbiter
    import shared_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input logic                 clk,
    input logic                 rst,
    shared_mem_arbiter_if.slave bus
);

    localparam int BE_WIDTH = be_width(DATA_WIDTH);

    if (!latency_ok(MEM_LATENCY)) begin : g_bad_latency
        $error("shared_mem_arbiter: MEM_LATENCY must be within 1..4");
    end

    // Priority register: owner of the last contested grant.
    owner_e last_grant;
    owner_e last_grant_nxt;

    // Grant decision for the current cycle.
    logic i_win;
    logic d_win;

    // Memory issue signals.
    logic                  issue_en;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [BE_WIDTH-1:0]   issue_we;
    logic [DATA_WIDTH-1:0] issue_din;

    // Tag line interface.
    logic   tag_in_valid;
    owner_e tag_in_owner;
    logic   tag_out_valid;
    owner_e tag_out_owner;

    // Response steering.
    logic                  i_hit;
    logic                  d_hit;
    logic [DATA_WIDTH-1:0] i_hold;
    logic [DATA_WIDTH-1:0] d_hold;

    // Priority register; I is treated as last winner so D takes the first conflict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= OWN_I;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    // Grant selection: a lone requester always wins, a conflict goes to the
    // side that did not win the previous conflict. Nothing is granted in reset.
    always_comb begin
        i_win          = 1'b0;
        d_win          = 1'b0;
        last_grant_nxt = last_grant;
        if (rst) begin
            if (bus.i_req_valid && bus.d_req_valid) begin
                if (last_grant == OWN_I) begin
                    d_win          = 1'b1;
                    last_grant_nxt = OWN_D;
                end else begin
                    i_win          = 1'b1;
                    last_grant_nxt = OWN_I;
                end
            end else begin
                i_win = bus.i_req_valid;
                d_win = bus.d_req_valid;
            end
        end
    end

    // Route the winner's request to the memory; fetches never write.
    always_comb begin
        issue_en   = i_win | d_win;
        issue_addr = '0;
        issue_we   = '0;
        issue_din  = '0;
        if (i_win) begin
            issue_addr = bus.i_req_addr;
        end else if (d_win) begin
            issue_addr = bus.d_req_addr;
            issue_we   = bus.d_req_be;
            issue_din  = bus.d_req_wdata;
        end
    end

    assign bus.i_req_ready = i_win;
    assign bus.d_req_ready = d_win;
    assign bus.mem_en      = issue_en;
    assign bus.mem_addr    = issue_addr;
    assign bus.mem_we      = issue_we;
    assign bus.mem_din     = issue_din;

    // Only reads expect data back; a D access with no byte enables is a read.
    always_comb begin
        tag_in_valid = i_win | (d_win && (bus.d_req_be == '0));
        tag_in_owner = d_win ? OWN_D : OWN_I;
    end

    shared_mem_arbiter_resp_tag_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (tag_in_valid),
        .in_owner  (tag_in_owner),
        .out_valid (tag_out_valid),
        .out_owner (tag_out_owner)
    );

    assign i_hit = tag_out_valid && (tag_out_owner == OWN_I);
    assign d_hit = tag_out_valid && (tag_out_owner == OWN_D);

    // Keep the last delivered word per requester so idle data outputs stay stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_hold <= '0;
            d_hold <= '0;
        end else begin
            if (i_hit) begin
                i_hold <= bus.mem_dout;
            end
            if (d_hit) begin
                d_hold <= bus.mem_dout;
            end
        end
    end

    assign bus.i_resp_valid = i_hit;
    assign bus.d_resp_valid = d_hit;
    assign bus.i_resp_data  = i_hit ? bus.mem_dout : i_hold;
    assign bus.d_resp_data  = d_hit ? bus.mem_dout : d_hold;

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Shares one single-port synchronous memory (BIOS/IMEM-style, fixed read latency) between two requesters: instruction fetch (I) and data load/store (D).
- Sits between the pipeline front-end/LSU and the memory macro.
- Round-robin grant, valid/ready request handshake, pipelined: one request issued per cycle.
- Tags each read with its owner so the response is returned to that requester after MEM_LATENCY cycles.

Parameters:
- ADDR_WIDTH, 14: word-address width to memory.
- DATA_WIDTH, 32: data width; byte-enable width is DATA_WIDTH/8.
- MEM_LATENCY, 1: cycles from mem_en to valid mem_dout. Legal range 1..4.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- i_req_valid  in  1  fetch request.
- i_req_addr  in  ADDR_WIDTH  fetch word address.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_resp_valid  out  1  fetch data valid (single-cycle pulse).
- i_resp_data  out  DATA_WIDTH  fetch data.
- d_req_valid  in  1  data request.
- d_req_addr  in  ADDR_WIDTH  data word address.
- d_req_be  in  DATA_WIDTH/8  byte write enables; 0 = read.
- d_req_wdata  in  DATA_WIDTH  store data.
- d_req_ready  out  1  data request accepted.
- d_resp_valid  out  1  load data valid (pulse).
- d_resp_data  out  DATA_WIDTH  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  DATA_WIDTH/8  memory byte write enables.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_din  out  DATA_WIDTH  memory write data.
- mem_dout  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en.

Behaviour:
- Handshake: a transfer occurs on a cycle where valid && ready. The requester holds valid and its payload stable until ready. ready is combinational from the valids and the priority register; ready never depends on the same requester's payload.
- Grant:
  - Only one valid asserted: that requester is granted.
  - Both asserted: the requester NOT granted last time wins.
  - Priority register last_grant (I/D) updates only on a contested grant.
  - Reset value of last_grant = I, so D wins the first conflict.
- Issue (combinational from the grant):
  - mem_en = (i_req_valid || d_req_valid).
  - mem_addr/mem_we/mem_din come from the winner.
  - I grant: mem_we = 0, mem_din = 0.
  - Idle: mem_addr = 0, mem_we = 0, mem_din = 0.
- Owner tracking: shift register MEM_LATENCY deep of {valid, owner}. A stage is loaded valid only for reads (I grant, or D grant with d_req_be == 0). Writes produce no response.
- Response:
  - When the tail stage is valid, the matching *_resp_valid = 1 for exactly one cycle.
  - The matching *_resp_data = mem_dout, combinational pass-through, latency-aligned.
  - Non-matching resp_data holds its last value (registered copy); it is 0 after reset.
- Throughput: one accepted request per cycle sustained. Under continuous contention, grants alternate I, D, I, D...; there is no starvation.
- Responses have no backpressure; requesters always accept.
- Simultaneous issue and response in the same cycle: both allowed, no interaction.
- Reset (rst == 0, any time):
  - Shift register cleared; in-flight responses are dropped, not replayed.
  - Outputs forced: i/d_req_ready = 0, i/d_resp_valid = 0, resp_data = 0, mem_en = 0, mem_we = 0.
  - Requests are ignored while rst == 0.
  - First grant is possible in the cycle after rst deasserts.
- Address wrap: none; the address is passed through unchanged.
- A D write to an address with an I read in flight is legal; the I read returns pre-write data (memory read-first).

Decomposition:
- Shared package holds: owner encoding constants (OWN_I = 0, OWN_D = 1), the MEM_LATENCY legal-range check, and the byte-enable width function.
- One natural sub-module: resp_tag_pipe, the parameterized {valid, owner} delay line of depth MEM_LATENCY with async active-low clear.

Test Plan:
- Reset: hold rst = 0 while i_req_valid = d_req_valid = 1 -> readies 0, mem_en 0. Release rst -> next cycle d_req_ready = 1, i_req_ready = 0 (D wins first conflict).
- Single fetch, MEM_LATENCY = 1: i_req addr 0x010, memory preloaded 0xDEADBEEF -> mem_addr 0x010 same cycle; i_resp_valid pulses one cycle later with 0xDEADBEEF; d_resp_valid stays 0.
- Contention: both valid for 6 cycles, I addrs 0x0..0x5, D reads 0x100..0x105 -> grant order D, I, D, I, D, I. Responses alternate d, i with the correct data; no drops.
- Store: d_req_be = 4'b0011, addr 0x20, wdata 0x12345678 -> mem_we 0011, no d_resp_valid. Subsequent D read of 0x20 returns 0x????5678 over the old upper half.
- Latency sweep MEM_LATENCY = 3: back-to-back I reads of 0x1, 0x2, 0x3 -> i_resp_valid high 3 consecutive cycles starting 3 cycles after the first issue, in order.
- Reset mid-flight: issue a D read (MEM_LATENCY = 2), assert rst one cycle later -> no d_resp_valid ever appears for that read; outputs at reset values.
